// File: rtl/mem_bank_arb.sv
// Per-bank round-robin arbiter. Each cycle it grants one client per SRAM bank and
// registers the bank selects. Read tags travel with each access so returning data reaches its owner.
module mem_bank_arb #(
    parameter int NUM_CLIENTS = 16,
    parameter int NUM_BANKS   = 16,
    parameter int RD_LAT      = 1,
    parameter int DW          = 256,
    localparam int CW         = $clog2(NUM_CLIENTS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_CLIENTS-1:0][NUM_BANKS-1:0]  req,
    input  logic [NUM_CLIENTS-1:0]                 req_we,
    output logic [NUM_CLIENTS-1:0][NUM_BANKS-1:0]  gnt,
    output logic [NUM_BANKS-1:0]                   bank_cs,
    output logic [NUM_BANKS-1:0]                   bank_we,
    output logic [NUM_BANKS-1:0][CW-1:0]           bank_owner,
    input  logic [NUM_BANKS-1:0][DW-1:0]           bank_rdata,
    output logic [NUM_BANKS-1:0]                   out_rvalid,
    output logic [NUM_BANKS-1:0][CW-1:0]           out_rclient,
    output logic [NUM_BANKS-1:0][DW-1:0]           out_rdata
);

    typedef logic [CW-1:0] cid_t;

    cid_t [NUM_BANKS-1:0]             ptr_q, ptr_d;
    cid_t [NUM_BANKS-1:0]             winner;
    logic [NUM_BANKS-1:0]             hit;
    logic [NUM_CLIENTS-1:0]           col, upper, sel;

    logic [NUM_BANKS-1:0]             cs_q, we_q;
    cid_t [NUM_BANKS-1:0]             owner_q;
    logic [RD_LAT-1:0][NUM_BANKS-1:0] tag_v_q;
    cid_t [RD_LAT-1:0][NUM_BANKS-1:0] tag_c_q;

    // NOTE: every variable in this block gets a default first, so no path can infer a latch.
    always_comb begin
        gnt    = '0;
        hit    = '0;
        winner = '0;
        ptr_d  = ptr_q;
        col    = '0;
        upper  = '0;
        sel    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                col[c]   = req[c][b];
                upper[c] = req[c][b] && (c >= int'(ptr_q[b]));
            end
            // Requesters at or above the pointer win first; otherwise wrap to the lowest requester.
            sel = (|upper) ? upper : col;
            for (int c = NUM_CLIENTS - 1; c >= 0; c--) begin
                if (sel[c]) winner[b] = cid_t'(c);
            end
            hit[b] = (|col) && !rst;
            if (hit[b]) begin
                gnt[winner[b]][b] = 1'b1;
                ptr_d[b] = (winner[b] == cid_t'(NUM_CLIENTS - 1)) ? '0 : winner[b] + 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag pipe is cleared as well, so reads still in flight at reset never surface.
            ptr_q   <= '0;
            cs_q    <= '0;
            we_q    <= '0;
            owner_q <= '0;
            tag_v_q <= '0;
            tag_c_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cs_q  <= hit;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (hit[b]) begin
                    we_q[b]    <= req_we[winner[b]];
                    owner_q[b] <= winner[b];
                end
            end
            tag_v_q[0] <= cs_q & ~we_q;
            tag_c_q[0] <= owner_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_c_q[i] <= tag_c_q[i-1];
            end
        end
    end

    assign bank_cs     = cs_q;
    assign bank_we     = we_q;
    assign bank_owner  = owner_q;
    assign out_rvalid  = tag_v_q[RD_LAT-1];
    assign out_rclient = tag_c_q[RD_LAT-1];
    assign out_rdata   = bank_rdata;

endmodule

// File: doc/mem_bank_arb.md
Name: mem_bank_arb

Overview:
- Per-bank arbiter directly downstream of the memory request controller.
- Consumes the client×bank request matrix and returns the grant matrix to the controller.
- Issues one chip-select per SRAM bank per cycle, with independent round-robin fairness per bank.
- Tags each read so the bank read data can be routed back to the owning client.

Parameters:
- NUM_CLIENTS, 16, number of requesting clients. Client id width CW = $clog2(NUM_CLIENTS).
- NUM_BANKS, 16, number of SRAM banks.
- RD_LAT, 1, SRAM read latency in cycles, from bank_cs to bank_rdata valid. Legal range 1..4.
- DW, 256, SRAM data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  [NUM_CLIENTS][NUM_BANKS]  req[c][b]: client c requests bank b
- req_we  in  [NUM_CLIENTS]  1 = write, 0 = read; applies to all of client c's requests this cycle
- gnt  out  [NUM_CLIENTS][NUM_BANKS]  combinational grant, same cycle as req
- bank_cs  out  [NUM_BANKS]  registered bank select
- bank_we  out  [NUM_BANKS]  registered write enable
- bank_owner  out  [NUM_BANKS][CW]  registered id of the granted client
- bank_rdata  in  [NUM_BANKS][DW]  SRAM read data
- out_rvalid  out  [NUM_BANKS]  read data valid
- out_rclient  out  [NUM_BANKS][CW]  owning client of the read data
- out_rdata  out  [NUM_BANKS][DW]  bank_rdata passthrough

Behaviour:
- Request rule: the requester holds req[c][b] (and req_we[c]) until it sees gnt[c][b]. Deasserting before grant is legal; the request is simply dropped.
- Per bank b:
  - Round-robin pointer ptr[b] (CW bits), reset to 0.
  - Winner = first c with req[c][b]=1, searching from ptr[b] upward with wrap at NUM_CLIENTS-1 → 0.
  - gnt[winner][b]=1. At most one gnt per bank column per cycle.
  - On grant, ptr[b] <= winner+1, mod NUM_CLIENTS. With no requests, ptr[b] holds.
- Banks are independent. One client may be granted up to NUM_BANKS banks in the same cycle (split unaligned access). It may also win one bank and lose another; the controller re-requests the lost one.
- Grant cycle T:
  - At T+1: bank_cs[b]=1, bank_we[b]=req_we[winner], bank_owner[b]=winner.
  - At T+1 with no grant at T: bank_cs=0; bank_we and bank_owner hold their previous values.
- Read return:
  - A tag shift register of depth RD_LAT per bank carries {valid = bank_cs & ~bank_we, owner}.
  - out_rvalid[b] and out_rclient[b] go active RD_LAT cycles after bank_cs, i.e. T+1+RD_LAT, aligned with bank_rdata.
  - out_rdata = bank_rdata, combinational.
  - Writes produce no out_rvalid.
- Back-to-back grants on the same bank every cycle are fully pipelined, with no bubbles.
- Reset (synchronous, rst=1 at a clock edge):
  - ptr = 0, bank_cs = 0, bank_we = 0, bank_owner = 0, tag pipe cleared, out_rvalid = 0, out_rclient = 0.
  - gnt is forced to all-zero while rst=1.
- Reset mid-operation: in-flight read tags are discarded, and no out_rvalid appears for accesses issued before reset.
- Reserved, not asserted: req for bank >= NUM_BANKS does not exist; X on req while rst=1 is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles with all req=1 → gnt=0, bank_cs=0, out_rvalid=0. First cycle after release: req[*][3]=1 → gnt[0][3]=1.
- Round-robin: clients 2, 5, 9 hold req on bank 0, RD_LAT=1 → grants 2, 5, 9, 2, 5 on consecutive cycles. bank_cs[0]=1 continuously from cycle 1; the ptr wrap 9→2 occurs with no idle cycle.
- Parallel banks: client 4 requests banks 6 and 7 with req_we=0, no contention → gnt[4][6]=gnt[4][7]=1 same cycle. Two cycles later out_rvalid[6]=out_rvalid[7]=1 with out_rclient=4, and out_rdata equals the bank_rdata driven.
- Split loss: client 1 requests banks 2 and 3; client 0 also requests bank 3 with ptr[3]=0 → client 1 granted bank 2 and client 0 bank 3. Next cycle client 1 re-requests bank 3 → granted.
- Write/read mix: client 7 writes bank 5, then client 8 reads bank 5 the following cycle → bank_we sequence 1,0 on bank 5. Exactly one out_rvalid with out_rclient=8, and none for the write.
- Reset mid-flight: read granted at T with RD_LAT=3, rst=1 at T+2 → out_rvalid stays 0 through T+6. ptr returns to 0: with clients 0 and 1 requesting, client 0 wins first.
